// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: frame constants and FSM state encoding.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         COUNT_W        = 16;
    localparam int         BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // Terminal states stop taking bytes so the host sees back-pressure instead of silent drops.
    function automatic logic state_accepts(input state_t s);
        return (s != S_DONE) && (s != S_ERROR);
    endfunction

endpackage

// File: rtl/program_loader_byte_word_packer.sv
// Byte-to-word assembler: MSB-first shift of stream bytes with a 2-bit byte counter.
module byte_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [23:0] r_partial;
    logic [1:0]  r_byte_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_partial  <= '0;
            r_byte_cnt <= '0;
        end else if (i_shift) begin
            r_partial  <= {r_partial[15:0], i_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    // Word is complete on the beat carrying its last byte; the caller registers it.
    assign o_word       = {r_partial, i_byte};
    assign o_word_valid = i_shift && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Frames a host byte stream into 32-bit program-memory writes and releases the CPU
// only after the load's XOR checksum matches.
//   state  | meaning
//   IDLE   | hunting for the sync byte
//   CNT_HI | expecting word count, high byte
//   CNT_LO | expecting word count, low byte; range check
//   DATA   | collecting data bytes, one write per 4 bytes
//   CSUM   | expecting checksum byte
//   DONE   | load good, CPU released (terminal)
//   ERROR  | load bad, CPU held (terminal)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            Byte_i,
    input  logic                  Byte_valid_i,
    output logic                  Byte_ready_o,
    output logic                  Wr_en_o,
    output logic [31:0]           Wr_addr_o,
    output logic [DATA_WIDTH-1:0] Wr_data_o,
    output logic                  Cpu_hold_o,
    output logic                  Done_o,
    output logic                  Error_o
);

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_count_hi;
    logic [7:0]           r_csum;
    logic [COUNT_W-1:0]   r_words_left;
    logic [31:0]          r_next_addr;

    logic                 w_beat;
    logic                 w_shift;
    logic                 w_word_valid;
    logic [31:0]          w_word;
    logic [COUNT_W-1:0]   w_count;
    logic                 w_count_bad;
    logic                 w_last_word;

    assign Byte_ready_o = ~reset & state_accepts(r_state);
    assign w_beat       = Byte_valid_i & Byte_ready_o;
    assign w_shift      = w_beat && (r_state == S_DATA);
    assign w_count      = {r_count_hi, Byte_i};
    assign w_count_bad  = (w_count == '0) || (w_count > COUNT_W'(MEMORY_DEPTH));
    assign w_last_word  = w_word_valid && (r_words_left == COUNT_W'(1));

    byte_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_shift      (w_shift),
        .i_byte       (Byte_i),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_beat) begin
            case (r_state)
                S_IDLE:   if (Byte_i == SYNC_BYTE) w_state_next = S_CNT_HI;
                S_CNT_HI: w_state_next = S_CNT_LO;
                S_CNT_LO: w_state_next = w_count_bad ? S_ERROR : S_DATA;
                S_DATA:   if (w_last_word) w_state_next = S_CSUM;
                S_CSUM:   w_state_next = (Byte_i == r_csum) ? S_DONE : S_ERROR;
                default:  w_state_next = r_state;
            endcase
        end
    end

    // Word counter runs down from N; the address register walks up in parallel.
    always_ff @(posedge clk) begin
        if (reset) begin
            Wr_en_o      <= 1'b0;
            Wr_addr_o    <= BASE_ADDR;
            Wr_data_o    <= '0;
            r_next_addr  <= BASE_ADDR;
            r_count_hi   <= '0;
            r_words_left <= '0;
            r_csum       <= '0;
        end else begin
            Wr_en_o <= w_word_valid;
            if (w_beat && (r_state == S_CNT_HI)) r_count_hi <= Byte_i;
            if (w_beat && (r_state == S_CNT_LO)) r_words_left <= w_count;
            if (w_shift) r_csum <= r_csum ^ Byte_i;
            if (w_word_valid) begin
                Wr_addr_o    <= r_next_addr;
                Wr_data_o    <= w_word;
                r_next_addr  <= r_next_addr + 32'(DATA_WIDTH / 8);
                r_words_left <= r_words_left - COUNT_W'(1);
            end
        end
    end

    assign Done_o     = (r_state == S_DONE);
    assign Error_o    = (r_state == S_ERROR);
    assign Cpu_hold_o = (r_state != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader against a frame-level reference model.
module tb_program_loader;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  Byte_i = 8'h00;
    logic        Byte_valid_i = 1'b0;
    logic        Byte_ready_o;
    logic        Wr_en_o;
    logic [31:0] Wr_addr_o;
    logic [31:0] Wr_data_o;
    logic        Cpu_hold_o;
    logic        Done_o;
    logic        Error_o;

    always #5 clk = ~clk;

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .Byte_i       (Byte_i),
        .Byte_valid_i (Byte_valid_i),
        .Byte_ready_o (Byte_ready_o),
        .Wr_en_o      (Wr_en_o),
        .Wr_addr_o    (Wr_addr_o),
        .Wr_data_o    (Wr_data_o),
        .Cpu_hold_o   (Cpu_hold_o),
        .Done_o       (Done_o),
        .Error_o      (Error_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] got_q[$];
    logic        prev_wr = 1'b0;

    logic [7:0]  stream[$];
    logic [63:0] exp_q[$];
    bit          exp_strobe[$];
    int          exp_accept;
    int          exp_term;
    bit          exp_done;
    bit          exp_err;

    logic [7:0]  frame1[12];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (Wr_en_o === 1'b1) begin
            got_q.push_back({Wr_addr_o, Wr_data_o});
            chk("strobe_width", 64'(prev_wr), 64'd0);
        end
        prev_wr = Wr_en_o;
    end

    // Reference: parse the byte list by the framing rules and list the writes it implies.
    task automatic build_model();
        int          pos;
        int          n;
        int          b;
        logic [7:0]  cs;
        logic [31:0] w;
        pos = 0;
        cs  = 8'h00;
        exp_q.delete();
        exp_strobe.delete();
        for (int i = 0; i < stream.size(); i++) exp_strobe.push_back(1'b0);
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        exp_term   = stream.size();
        exp_accept = stream.size();
        while (pos < stream.size() && stream[pos] != 8'hA5) pos++;
        if (pos + 2 >= stream.size()) return;
        n = int'({stream[pos+1], stream[pos+2]});
        if (n == 0 || n > DEPTH) begin
            exp_err    = 1'b1;
            exp_term   = pos + 2;
            exp_accept = pos + 3;
            return;
        end
        for (int k = 0; k < n; k++) begin
            b = pos + 3 + 4 * k;
            if (b + 3 >= stream.size()) return;
            w = {stream[b], stream[b+1], stream[b+2], stream[b+3]};
            cs = cs ^ stream[b] ^ stream[b+1] ^ stream[b+2] ^ stream[b+3];
            exp_q.push_back({BASE + 32'(4 * k), w});
            exp_strobe[b+3] = 1'b1;
        end
        if (pos + 3 + 4 * n >= stream.size()) return;
        exp_term   = pos + 3 + 4 * n;
        exp_accept = exp_term + 1;
        if (stream[exp_term] == cs) exp_done = 1'b1;
        else                        exp_err  = 1'b1;
    endtask

    task automatic apply_reset(input bit check);
        @(negedge clk);
        reset = 1'b1;
        Byte_valid_i = 1'b0;
        #1;
        if (check) chk("ready_in_reset", 64'(Byte_ready_o), 64'd0);
        @(posedge clk);
        #1;
        if (check) begin
            chk("rst_wr_en", 64'(Wr_en_o), 64'd0);
            chk("rst_addr",  64'(Wr_addr_o), 64'(BASE));
            chk("rst_data",  64'(Wr_data_o), 64'd0);
            chk("rst_done",  64'(Done_o), 64'd0);
            chk("rst_error", 64'(Error_o), 64'd0);
            chk("rst_hold",  64'(Cpu_hold_o), 64'd1);
        end
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic run_stream(input string tag, input int max_gap);
        int accepted;
        bit rdy;
        accepted = 0;
        build_model();
        got_q.delete();
        for (int i = 0; i < stream.size(); i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            @(negedge clk);
            Byte_i       = stream[i];
            Byte_valid_i = 1'b1;
            rdy          = Byte_ready_o;
            @(posedge clk);
            #1;
            Byte_valid_i = 1'b0;
            if (!rdy) break;
            accepted++;
            chk({tag, "_strobe"}, 64'(Wr_en_o), 64'(exp_strobe[i]));
            chk({tag, "_done_lat"}, 64'(Done_o), 64'(exp_done && i >= exp_term));
            chk({tag, "_err_lat"}, 64'(Error_o), 64'(exp_err && i >= exp_term));
        end
        repeat (2) @(negedge clk);
        chk({tag, "_accepted"}, 64'(accepted), 64'(exp_accept));
        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            chk({tag, "_write"}, got_q[j], exp_q[j]);
        chk({tag, "_done"}, 64'(Done_o), 64'(exp_done));
        chk({tag, "_error"}, 64'(Error_o), 64'(exp_err));
        chk({tag, "_hold"}, 64'(Cpu_hold_o), 64'(!exp_done));
        chk({tag, "_ready"}, 64'(Byte_ready_o), 64'(!(exp_done || exp_err)));
    endtask

    task automatic push_frame1(input logic [7:0] csum);
        for (int i = 0; i < 11; i++) stream.push_back(frame1[i]);
        stream.push_back(csum);
    endtask

    task automatic push_random_frame(input int n, input bit bad_cs);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [15:0] nn;
        cs = 8'h00;
        nn = 16'(n);
        stream.push_back(8'hA5);
        stream.push_back(nn[15:8]);
        stream.push_back(nn[7:0]);
        repeat (4 * n) begin
            b = 8'($urandom);
            cs = cs ^ b;
            stream.push_back(b);
        end
        stream.push_back(bad_cs ? (cs ^ 8'(1 << $urandom_range(7, 0))) : cs);
    endtask

    initial begin
        frame1 = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h00, 8'h00, 8'h00, 8'h0C, 8'h21};

        apply_reset(1'b1);

        stream.delete(); push_frame1(8'h21);
        run_stream("nominal", 0);
        chk("nominal_w0", got_q.size() > 0 ? got_q[0] : 64'hx, {32'h0040_0000, 32'h2008_0005});
        chk("nominal_w1", got_q.size() > 1 ? got_q[1] : 64'hx, {32'h0040_0004, 32'h0000_000C});

        apply_reset(1'b0);
        stream.delete();
        stream.push_back(8'h00); stream.push_back(8'hFF); stream.push_back(8'h5A);
        push_frame1(8'h21);
        run_stream("sync_hunt", 0);

        apply_reset(1'b0);
        stream.delete(); push_frame1(8'h22); stream.push_back(8'h00);
        run_stream("bad_csum", 0);

        apply_reset(1'b0);
        stream.delete();
        stream.push_back(8'hA5); stream.push_back(8'h00); stream.push_back(8'h41);
        stream.push_back(8'h00);
        run_stream("count_over", 0);

        apply_reset(1'b0);
        stream.delete();
        stream.push_back(8'hA5); stream.push_back(8'h00); stream.push_back(8'h00);
        stream.push_back(8'h12);
        run_stream("count_zero", 0);

        apply_reset(1'b0);
        stream.delete(); push_random_frame(DEPTH, 1'b0);
        run_stream("count_max", 0);
        chk("count_max_last_addr", got_q.size() == DEPTH ? 64'(got_q[DEPTH-1][63:32]) : 64'hx,
            64'h0040_00FC);

        apply_reset(1'b0);
        stream.delete(); push_frame1(8'h21);
        run_stream("gapped", 5);

        apply_reset(1'b0);
        stream.delete();
        stream.push_back(8'hA5); stream.push_back(8'h00); stream.push_back(8'h01);
        stream.push_back(8'h20); stream.push_back(8'h08);
        run_stream("partial", 0);
        apply_reset(1'b1);
        stream.delete();
        stream.push_back(8'hA5); stream.push_back(8'h00); stream.push_back(8'h01);
        stream.push_back(8'hAA); stream.push_back(8'hBB); stream.push_back(8'hCC);
        stream.push_back(8'hDD); stream.push_back(8'h00);
        run_stream("after_reset", 0);
        chk("after_reset_w0", got_q.size() > 0 ? got_q[0] : 64'hx, {32'h0040_0000, 32'hAABB_CCDD});

        for (int t = 0; t < 8; t++) begin
            logic [7:0] junk;
            apply_reset(1'b0);
            stream.delete();
            repeat ($urandom_range(3, 0)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                stream.push_back(junk);
            end
            push_random_frame($urandom_range(8, 1), 1'($urandom_range(1, 0)));
            stream.push_back(8'($urandom));
            run_stream("random", 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
